// File: rtl/step_pkg.sv
// Shared types and elaboration-time parameter checks for the step/ramp pulse generator.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  function automatic bit params_ok(input longint min_period, input longint max_period,
                                   input longint step_high, input longint period_w);
    return (min_period > step_high) && (max_period >= min_period) &&
           (max_period < (64'sd1 <<< period_w));
  endfunction

endpackage

// File: rtl/step_ramp_calc.sv
// Next step period and ramp depth after one period: decelerate, accelerate or cruise.
module step_ramp_calc
  import step_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 10000,
  parameter int MAX_PERIOD = 40000,
  parameter int RAMP_DEC   = 2000
) (
  input  logic [COUNT_W-1:0]  remaining,
  input  logic [COUNT_W-1:0]  ramp_cnt,
  input  logic [PERIOD_W-1:0] cur_period,
  output logic [PERIOD_W-1:0] next_period,
  output logic [COUNT_W-1:0]  next_ramp
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] DEC_P = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W:0]   DEC_W = (PERIOD_W+1)'(RAMP_DEC);
  localparam logic [PERIOD_W:0]   MAX_W = (PERIOD_W+1)'(MAX_PERIOD);
  localparam logic [PERIOD_W:0]   FLOOR_W = (PERIOD_W+1)'(MIN_PERIOD + RAMP_DEC);

  logic [PERIOD_W:0] up;

  // One extra bit keeps the saturation compares free of wrap-around.
  assign up = {1'b0, cur_period} + DEC_W;

  always_comb begin
    next_period = cur_period;
    next_ramp   = ramp_cnt;
    if (remaining <= ramp_cnt) begin
      next_period = (up >= MAX_W) ? MAX_P : up[PERIOD_W-1:0];
      if (ramp_cnt != '0) next_ramp = ramp_cnt - COUNT_W'(1);
    end else if (cur_period > MIN_P) begin
      next_period = ({1'b0, cur_period} >= FLOOR_W) ? cur_period - DEC_P : MIN_P;
      next_ramp   = ramp_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/step_ramp_controller.sv
// Single-axis stepper pulse generator: dir setup, trapezoidal period ramp, position and abort.
module step_ramp_controller
  import step_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int POS_W      = 32,
  parameter int PERIOD_W   = 16,
  parameter int STEP_HIGH  = 2000,
  parameter int MIN_PERIOD = 10000,
  parameter int MAX_PERIOD = 40000,
  parameter int RAMP_DEC   = 2000,
  parameter int DIR_SETUP  = 500
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COUNT_W-1:0] cmd_steps,
  input  logic                      abort,
  input  logic                      pos_clear,
  output logic                      step,
  output logic                      dir,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic signed [POS_W-1:0]   position
);

  if (!params_ok(MIN_PERIOD, MAX_PERIOD, STEP_HIGH, PERIOD_W)) begin : g_param_check
    $error("step_ramp_controller: need MIN_PERIOD > STEP_HIGH, MAX_PERIOD >= MIN_PERIOD, MAX_PERIOD < 2**PERIOD_W");
  end

  localparam int SETUP_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic [SETUP_W-1:0]  SETUP_LAST = SETUP_W'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] MAX_P      = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] HIGH_P     = PERIOD_W'(STEP_HIGH);

  state_t               state;
  logic [COUNT_W-1:0]   remaining, ramp_cnt, magnitude, rem_next, calc_ramp;
  logic [PERIOD_W-1:0]  cur_period, period_cnt, cnt_next, calc_period;
  logic [SETUP_W-1:0]   setup_cnt;
  logic                 period_end, rise;
  logic signed [POS_W-1:0] pos_base;

  step_ramp_calc #(
    .COUNT_W   (COUNT_W),
    .PERIOD_W  (PERIOD_W),
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD),
    .RAMP_DEC  (RAMP_DEC)
  ) u_calc (
    .remaining  (rem_next),
    .ramp_cnt   (ramp_cnt),
    .cur_period (cur_period),
    .next_period(calc_period),
    .next_ramp  (calc_ramp)
  );

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign magnitude  = cmd_steps[COUNT_W-1] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);
  assign rem_next   = remaining - COUNT_W'(1);
  assign cnt_next   = period_cnt + PERIOD_W'(1);
  assign period_end = (period_cnt == cur_period - PERIOD_W'(1));
  assign pos_base   = pos_clear ? '0 : position;

  // Rise decision mirrors the FSM so position moves on exactly the edge step goes high.
  assign rise = !abort &&
                (((state == SETUP) && (setup_cnt == SETUP_LAST)) ||
                 ((state == PULSE) && period_end && (rem_next != '0)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= DIR_NEG;
      done       <= 1'b0;
      aborted    <= 1'b0;
      position   <= '0;
      remaining  <= '0;
      ramp_cnt   <= '0;
      cur_period <= MAX_P;
      period_cnt <= '0;
      setup_cnt  <= '0;
    end else begin
      done     <= 1'b0;
      position <= rise ? pos_base + (dir ? POS_W'(1) : '1) : pos_base;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir        <= cmd_steps[COUNT_W-1] ? DIR_NEG : DIR_POS;
            remaining  <= magnitude;
            cur_period <= MAX_P;
            ramp_cnt   <= '0;
            setup_cnt  <= '0;
            aborted    <= 1'b0;
            if (magnitude == '0) done  <= 1'b1;
            else                 state <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (setup_cnt == SETUP_LAST) begin
            state      <= PULSE;
            step       <= 1'b1;
            period_cnt <= '0;
          end else begin
            setup_cnt <= setup_cnt + SETUP_W'(1);
          end
        end
        PULSE: begin
          if (period_end) begin
            remaining <= rem_next;
            if (rem_next == '0 || abort) begin
              state   <= IDLE;
              done    <= 1'b1;
              aborted <= abort && (rem_next != '0);
              step    <= 1'b0;
            end else begin
              cur_period <= calc_period;
              ramp_cnt   <= calc_ramp;
              period_cnt <= '0;
              step       <= 1'b1;
            end
          end else begin
            period_cnt <= cnt_next;
            step       <= (cnt_next < HIGH_P);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_ramp_controller.sv
// Scoreboard bench: commands push expected pulses/done events; a negedge monitor pops and compares.
module tb_step_ramp_controller;

  localparam int COUNT_W = 4;
  localparam int SH = 4, MINP = 10, MAXP = 20, RD = 5, DS = 3;

  logic clock = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0, pos_clear = 1'b0;
  logic signed [COUNT_W-1:0] cmd_steps = '0;
  logic cmd_ready, step, dir, busy, done, aborted;
  logic signed [31:0] position;

  step_ramp_controller #(
    .COUNT_W(COUNT_W), .POS_W(32), .PERIOD_W(16), .STEP_HIGH(SH),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .RAMP_DEC(RD), .DIR_SETUP(DS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .abort(abort), .pos_clear(pos_clear), .step(step), .dir(dir),
    .busy(busy), .done(done), .aborted(aborted), .position(position)
  );

  always #5 clock = ~clock;

  typedef struct { int interval; int dir; int pos; } pulse_t;
  typedef struct { int delay; int abrt; int pos; } done_t;
  pulse_t exp_p[$];
  done_t  exp_d[$];

  int checks = 0, errors = 0;
  int cyc = 0, ref_cyc = 0, rise_cyc = 0, rise_cnt = 0, model_pos = 0;
  bit mon_en = 0, step_q = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference profile: pulse intervals, positions and the final done event for one command.
  task automatic push_move(input int n, input int stop_after);
    int m, per, ramp, rem, cnt, prev;
    pulse_t p;
    done_t d;
    m = (n < 0) ? -n : n;
    per = MAXP; ramp = 0; rem = m; prev = 0;
    cnt = (stop_after > 0 && stop_after < m) ? stop_after : m;
    for (int k = 0; k < cnt; k++) begin
      model_pos += (n >= 0) ? 1 : -1;
      p.interval = (k == 0) ? DS + 1 : prev;
      p.dir = (n >= 0) ? 1 : 0;
      p.pos = model_pos;
      exp_p.push_back(p);
      prev = per;
      rem--;
      if (rem <= ramp) begin
        per = (per + RD > MAXP) ? MAXP : per + RD;
        ramp--;
      end else if (per > MINP) begin
        per = (per - RD < MINP) ? MINP : per - RD;
        ramp++;
      end
    end
    d.delay = prev; d.abrt = (cnt < m) ? 1 : 0; d.pos = model_pos;
    exp_d.push_back(d);
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mon_en) begin
      if (step && !step_q) begin
        rise_cnt++;
        if (exp_p.size() == 0) chk("extra_pulse", exp_p.size(), 1);
        else begin
          pulse_t e;
          e = exp_p.pop_front();
          chk("interval", cyc - ref_cyc, e.interval);
          chk("dir", dir, e.dir);
          chk("position", position, e.pos);
          chk("ready_busy", cmd_ready, 0);
        end
        ref_cyc = cyc;
        rise_cyc = cyc;
      end
      if (!step && step_q) chk("high_len", cyc - rise_cyc, SH);
      if (done) begin
        if (exp_d.size() == 0) chk("extra_done", exp_d.size(), 1);
        else begin
          done_t d;
          d = exp_d.pop_front();
          chk("done_delay", cyc - ref_cyc, d.delay);
          chk("aborted", aborted, d.abrt);
          chk("done_pos", position, d.pos);
        end
      end
      if (cmd_valid && cmd_ready) ref_cyc = cyc + 1;
    end
    step_q = step;
  end

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      got = cmd_ready;
    end
    chk("accept_wait", got, 1);
  endtask

  task automatic send(input int n, input int stop_after);
    @(posedge clock); #1;
    cmd_steps = COUNT_W'(n);
    cmd_valid = 1'b1;
    push_move(n, stop_after);
    wait_accept();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(posedge clock);
      if (exp_p.size() == 0 && exp_d.size() == 0) break;
    end
    chk("drain", exp_p.size() + exp_d.size(), 0);
  endtask

  task automatic clear_pos();
    @(posedge clock); #1 pos_clear = 1'b1;
    @(posedge clock); #1 pos_clear = 1'b0;
    model_pos = 0;
    @(negedge clock);
    chk("pos_clear", position, 0);
  endtask

  initial begin
    int start;
    bit got;
    repeat (3) @(negedge clock);
    chk("rst_step", step, 0);   chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0); chk("rst_pos", position, 0);
    chk("rst_ready", cmd_ready, 1);
    reset_n = 1'b1;
    mon_en = 1;

    send(6, 0);  wait_idle();
    clear_pos();
    send(3, 0);  wait_idle();
    send(-2, 0); wait_idle();
    clear_pos();
    send(-8, 0); wait_idle();
    send(0, 0);  wait_idle();
    chk("zero_dir", dir, 1);

    clear_pos();
    start = rise_cnt;
    send(6, 3);
    for (int i = 0; i < 600 && rise_cnt < start + 3; i++) @(posedge clock);
    #1 abort = 1'b1;
    wait_idle();
    #1 abort = 1'b0;
    repeat (40) @(posedge clock);
    chk("abort_pulses", rise_cnt - start, 3);

    send(3, 0);
    @(posedge clock); #1;
    cmd_steps = COUNT_W'(-2);
    cmd_valid = 1'b1;
    push_move(-2, 0);
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      got = cmd_ready;
    end
    chk("accept_in_done", done, 1);
    @(posedge clock); #1 cmd_valid = 1'b0;
    wait_idle();

    start = rise_cnt;
    send(6, 0);
    for (int i = 0; i < 600 && rise_cnt < start + 2; i++) @(posedge clock);
    mon_en = 0;
    #3 reset_n = 1'b0;
    #1;
    chk("async_step", step, 0);
    chk("async_busy", busy, 0);
    chk("async_pos", position, 0);
    exp_p.delete();
    exp_d.delete();
    model_pos = 0;
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", cmd_ready, 1);
    mon_en = 1;
    send(1, 0); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
